z_shake_detector: RTL and testbench
===================================

Z_SHAKE_DETECTOR -- requirements
Module: z_shake_detector

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, giving a moving-average window of 2^AVG_LOG2 samples.
REQ-002 SHALL have parameter CAL_LOG2, default 4, giving 2^CAL_LOG2 averages per baseline calibration.
REQ-003 SHALL have parameter THRESH, default 200, the trip deviation in LSB (unsigned 16-bit).
REQ-004 SHALL have parameter HYST, default 50, the release hysteresis in LSB; HYST < THRESH required.
REQ-005 SHALL have parameter HOLD, default 4, the consecutive qualifying averages needed to enter or leave the shake state (1..15).
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 z_data  in  16  signed Z sample from the accelerometer reader.
REQ-009 z_valid  in  1  one-cycle strobe; z_data is sampled on this cycle; may assert back-to-back.
REQ-010 recal  in  1  one-cycle request to recalibrate the baseline.
REQ-011 z_avg  out  16  signed moving average.
REQ-012 avg_valid  out  1  one-cycle strobe, z_avg updated.
REQ-013 baseline  out  16  signed calibrated rest level.
REQ-014 calibrated  out  1  level, baseline is valid.
REQ-015 shake  out  1  level, motion detected.
REQ-016 shake_pulse  out  1  one-cycle strobe on shake rising.
REQ-017 shake_count  out  8  number of shake events, saturating.

Function
REQ-018 SHALL keep a circular buffer of 2^AVG_LOG2 samples and a signed running sum of 16+AVG_LOG2 bits; on z_valid: sum = sum + z_data - oldest, write z_data over oldest, pointer wraps modulo depth.
REQ-019 SHALL register z_avg = new sum arithmetically shifted right by AVG_LOG2 (floor toward -inf), with avg_valid high the cycle after the z_valid edge (latency 1).
REQ-020 SHALL suppress avg_valid until the buffer holds 2^AVG_LOG2 samples since reset; buffer contents before fill SHALL be treated as zero.
REQ-021 SHALL implement states FILL, CAL, QUIET and ACTIVE; reset enters FILL.
REQ-022 FILL -> CAL on the first avg_valid; that average is the first calibration average.
REQ-023 CAL SHALL accumulate 2^CAL_LOG2 averages; on the last one, baseline = sum >>> CAL_LOG2, calibrated = 1 and the state moves to QUIET, all on the same edge.
REQ-024 dev = |z_avg - baseline|, computed at 17 bits, unsigned, no overflow.
REQ-025 In QUIET a hit counter SHALL increment per average with dev > THRESH (strict) and clear on any average with dev <= THRESH.
REQ-026 When the hit counter reaches HOLD, the block SHALL enter ACTIVE, set shake = 1, pulse shake_pulse for one cycle, increment shake_count (held at 255) and clear the counter.
REQ-027 In ACTIVE the counter SHALL increment per average with dev < THRESH - HYST (strict) and clear otherwise; at HOLD the block SHALL enter QUIET with shake = 0.
REQ-028 recal SHALL move the block from QUIET/ACTIVE to CAL and clear shake, the hit counter and calibrated; shake_count and the buffer SHALL be kept.
REQ-029 recal in FILL or CAL SHALL restart calibration accumulation only.
REQ-030 recal coincident with avg_valid SHALL take priority; that average SHALL NOT be counted for calibration or detection.
REQ-031 Detection SHALL evaluate only on avg_valid cycles; other cycles hold all state.

Reset
REQ-032 While reset is asserted the block SHALL be in FILL with buffer, sum, pointer, fill count and counters zeroed, and every output 0.
REQ-033 Reset asserted mid-operation SHALL abandon all state immediately, with no partial-state carryover.

Verification
REQ-034 Constant z = 1000, 24 samples -> first avg_valid after sample 8 with z_avg = 1000; calibrated rises after sample 23 with baseline = 1000.
REQ-035 After calibration, step to z = 1300 -> averages 1225, 1262, 1300, 1300 on step samples 6-9; shake and shake_pulse after sample 9; shake_count = 1.
REQ-036 Then return to z = 1000 -> first qualifying average 1112 at sample 5; shake falls after sample 8 of the return.
REQ-037 After calibration at 1000, constant z = 1200 (dev exactly 200) for 50 samples -> shake stays 0; 1201 sustained trips after 4 qualifying averages.
REQ-038 Constant z = -3 -> z_avg = -3; window summing to -9 -> z_avg = -2; calibration at -3 -> baseline = -3.
REQ-039 Reset asserted in ACTIVE with shake_count = 5 -> all outputs 0 at once; after release, no avg_valid until 8 new samples. recal during ACTIVE -> shake 0, calibrated 0, count kept.

Source files
------------

// File: rtl/z_shake_detector_if.sv
// -----------------------------------------------------------------------------
// z_shake_detector_if
//
// Purpose:
//   Groups the sample-stream inputs and the detection outputs of
//   z_shake_detector into one bundle. The clock and reset stay plain ports on
//   the detector.
//
// Signals:
//   z_data       16  signed Z sample from the accelerometer reader
//   z_valid       1  one-cycle strobe, z_data sampled this cycle
//   recal         1  one-cycle request to recalibrate the baseline
//   z_avg        16  signed moving average
//   avg_valid     1  one-cycle strobe, z_avg updated
//   baseline     16  signed calibrated rest level
//   calibrated    1  level, baseline is valid
//   shake         1  level, motion detected
//   shake_pulse   1  one-cycle strobe on shake rising
//   shake_count   8  number of shake events, saturating at 255
//
// Modports:
//   master  sample source / consumer side (drives z_data, z_valid, recal)
//   slave   detector side (drives the averaged and detection outputs)
// -----------------------------------------------------------------------------
interface z_shake_detector_if;

    logic signed [15:0] z_data;
    logic               z_valid;
    logic               recal;

    logic signed [15:0] z_avg;
    logic               avg_valid;
    logic signed [15:0] baseline;
    logic               calibrated;
    logic               shake;
    logic               shake_pulse;
    logic [7:0]         shake_count;

    modport master (
        output z_data,
        output z_valid,
        output recal,
        input  z_avg,
        input  avg_valid,
        input  baseline,
        input  calibrated,
        input  shake,
        input  shake_pulse,
        input  shake_count
    );

    modport slave (
        input  z_data,
        input  z_valid,
        input  recal,
        output z_avg,
        output avg_valid,
        output baseline,
        output calibrated,
        output shake,
        output shake_pulse,
        output shake_count
    );

endinterface : z_shake_detector_if

// File: rtl/z_shake_detector.sv
// -----------------------------------------------------------------------------
// z_shake_detector
//
// Purpose:
//   Smooths a stream of signed Z accelerometer samples with a 2^AVG_LOG2 box
//   filter, calibrates a rest baseline from 2^CAL_LOG2 averages, and flags
//   "shake" when the average departs from the baseline by more than THRESH for
//   HOLD consecutive averages. Shake is released after HOLD consecutive
//   averages closer than THRESH - HYST.
//
// Parameters:
//   AVG_LOG2  log2 of moving-average window depth (>= 1)
//   CAL_LOG2  log2 of averages accumulated per baseline calibration
//   THRESH    trip deviation in LSB
//   HYST      release hysteresis in LSB (HYST < THRESH)
//   HOLD      consecutive qualifying averages to enter/leave shake (1..15)
//
// Ports:
//   clk    in   clock, all state on rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of z_shake_detector_if (sample stream + results)
//
// Timing:
//   z_valid on cycle N -> avg_valid/z_avg on cycle N+1 (once the window has
//   been filled since reset). The detector reacts to that average on the
//   following edge, so shake/calibrated/baseline move on cycle N+2.
// -----------------------------------------------------------------------------
module z_shake_detector #(
    parameter int AVG_LOG2 = 3,
    parameter int CAL_LOG2 = 4,
    parameter int THRESH   = 200,
    parameter int HYST     = 50,
    parameter int HOLD     = 4
) (
    input  logic                clk,
    input  logic                reset,
    z_shake_detector_if.slave   bus
);

    localparam int DEPTH     = 1 << AVG_LOG2;
    localparam int SUM_W     = 16 + AVG_LOG2;
    localparam int FILL_W    = AVG_LOG2 + 1;
    localparam int CAL_N     = 1 << CAL_LOG2;
    localparam int CAL_W     = 16 + CAL_LOG2;
    localparam int CAL_CNT_W = CAL_LOG2 + 1;

    localparam logic [16:0] TRIP_LVL    = 17'(THRESH);
    localparam logic [16:0] RELEASE_LVL = 17'(THRESH - HYST);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,  // window not yet full, no averages yet
        S_CAL    = 2'd1,  // accumulating averages for the baseline
        S_QUIET  = 2'd2,  // calibrated, no motion
        S_ACTIVE = 2'd3   // calibrated, motion detected
    } state_t;

    // -------------------------------------------------------------------------
    // Moving-average datapath
    // -------------------------------------------------------------------------
    logic signed [15:0]      win_q [DEPTH];
    logic [AVG_LOG2-1:0]     ptr_q;
    logic [FILL_W-1:0]       fill_q;
    logic [FILL_W-1:0]       fill_d;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [15:0]      z_avg_q;
    logic signed [15:0]      z_avg_d;
    logic                    avg_valid_q;
    logic                    window_full;

    // The sum stays exact in modular arithmetic: the new value is always the
    // true sum of the current window, which fits SUM_W bits.
    always_comb begin
        sum_d       = sum_q + SUM_W'(bus.z_data) - SUM_W'(win_q[ptr_q]);
        z_avg_d     = 16'(sum_d >>> AVG_LOG2);
        fill_d      = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
        window_full = (fill_d == FILL_W'(DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the sample window is reset as well because slots not yet written
    // since reset must read as zero for the running sum to stay exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            ptr_q       <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            z_avg_q     <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (bus.z_valid) begin
                win_q[ptr_q] <= bus.z_data;
                ptr_q        <= ptr_q + AVG_LOG2'(1);   // wraps modulo DEPTH
                sum_q        <= sum_d;
                fill_q       <= fill_d;
                if (window_full) begin
                    z_avg_q     <= z_avg_d;
                    avg_valid_q <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Calibration / detection FSM
    // -------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic signed [CAL_W-1:0] cal_sum_q, cal_sum_d;
    logic [CAL_CNT_W-1:0]    cal_cnt_q, cal_cnt_d;
    logic [3:0]              hit_q, hit_d;
    logic signed [15:0]      baseline_q, baseline_d;
    logic                    calibrated_q, calibrated_d;
    logic                    shake_q, shake_d;
    logic                    shake_pulse_q, shake_pulse_d;
    logic [7:0]              count_q, count_d;

    logic signed [CAL_W-1:0] cal_acc;
    logic signed [16:0]      diff;
    logic [16:0]             dev;
    logic [3:0]              hit_inc;

    // Deviation at 17 bits: the difference of two 16-bit signed values always
    // fits, and its magnitude (at most 65535) fits unsigned.
    always_comb begin
        diff    = {z_avg_q[15], z_avg_q} - {baseline_q[15], baseline_q};
        dev     = diff[16] ? (~diff + 17'd1) : diff;
        cal_acc = cal_sum_q + CAL_W'(z_avg_q);
        hit_inc = hit_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FILL;
            cal_sum_q     <= '0;
            cal_cnt_q     <= '0;
            hit_q         <= '0;
            baseline_q    <= '0;
            calibrated_q  <= 1'b0;
            shake_q       <= 1'b0;
            shake_pulse_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cal_sum_q     <= cal_sum_d;
            cal_cnt_q     <= cal_cnt_d;
            hit_q         <= hit_d;
            baseline_q    <= baseline_d;
            calibrated_q  <= calibrated_d;
            shake_q       <= shake_d;
            shake_pulse_q <= shake_pulse_d;
            count_q       <= count_d;
        end
    end

    // NOTE: every signal written here gets its hold/default value first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cal_sum_d     = cal_sum_q;
        cal_cnt_d     = cal_cnt_q;
        hit_d         = hit_q;
        baseline_d    = baseline_q;
        calibrated_d  = calibrated_q;
        shake_d       = shake_q;
        shake_pulse_d = 1'b0;
        count_d       = count_q;

        if (bus.recal) begin
            // Recalibration wins over a coincident average, which is dropped.
            cal_sum_d = '0;
            cal_cnt_d = '0;
            if (state_q == S_QUIET || state_q == S_ACTIVE) begin
                state_d      = S_CAL;
                shake_d      = 1'b0;
                hit_d        = '0;
                calibrated_d = 1'b0;
            end
        end else if (avg_valid_q) begin
            unique case (state_q)
                // The first average after fill is also the first calibration
                // average, so FILL and CAL share the accumulation path.
                S_FILL, S_CAL: begin
                    if (cal_cnt_q == CAL_CNT_W'(CAL_N - 1)) begin
                        baseline_d   = 16'(cal_acc >>> CAL_LOG2);
                        calibrated_d = 1'b1;
                        cal_sum_d    = '0;
                        cal_cnt_d    = '0;
                        hit_d        = '0;
                        state_d      = S_QUIET;
                    end else begin
                        cal_sum_d = cal_acc;
                        cal_cnt_d = cal_cnt_q + CAL_CNT_W'(1);
                        state_d   = S_CAL;
                    end
                end

                S_QUIET: begin
                    if (dev > TRIP_LVL) begin
                        if (hit_inc == 4'(HOLD)) begin
                            state_d       = S_ACTIVE;
                            shake_d       = 1'b1;
                            shake_pulse_d = 1'b1;
                            hit_d         = '0;
                            if (count_q != 8'hFF) begin
                                count_d = count_q + 8'd1;
                            end
                        end else begin
                            hit_d = hit_inc;
                        end
                    end else begin
                        hit_d = '0;
                    end
                end

                S_ACTIVE: begin
                    if (dev < RELEASE_LVL) begin
                        if (hit_inc == 4'(HOLD)) begin
                            state_d = S_QUIET;
                            shake_d = 1'b0;
                            hit_d   = '0;
                        end else begin
                            hit_d = hit_inc;
                        end
                    end else begin
                        hit_d = '0;
                    end
                end

                default: state_d = S_FILL;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign bus.z_avg       = z_avg_q;
    assign bus.avg_valid   = avg_valid_q;
    assign bus.baseline    = baseline_q;
    assign bus.calibrated  = calibrated_q;
    assign bus.shake       = shake_q;
    assign bus.shake_pulse = shake_pulse_q;
    assign bus.shake_count = count_q;

endmodule : z_shake_detector

// File: tb/tb_z_shake_detector.sv
// -----------------------------------------------------------------------------
// tb_z_shake_detector
//
// Directed bench for z_shake_detector with default parameters
// (window 8, 16 calibration averages, THRESH 200, HYST 50, HOLD 4).
// Each sample is presented as a one-cycle z_valid pulse; the average is
// observed one cycle later and the detector state one cycle after that.
// -----------------------------------------------------------------------------
module tb_z_shake_detector;

    logic clk = 1'b0;
    logic reset;

    z_shake_detector_if bus ();

    z_shake_detector #(
        .AVG_LOG2 (3),
        .CAL_LOG2 (4),
        .THRESH   (200),
        .HYST     (50),
        .HOLD     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic               got_avg_valid;
    logic signed [15:0] got_avg;
    logic               got_pulse;

    // One sample: z_valid for one cycle, capture the average the cycle after,
    // optionally raise recal coincident with that average, then capture the
    // detector reaction one cycle later.
    task automatic send(input logic signed [15:0] v, input bit with_recal);
        @(negedge clk);
        bus.z_data  = v;
        bus.z_valid = 1'b1;
        @(negedge clk);
        bus.z_valid   = 1'b0;
        got_avg_valid = bus.avg_valid;
        got_avg       = bus.z_avg;
        if (with_recal) bus.recal = 1'b1;
        @(negedge clk);
        bus.recal = 1'b0;
        got_pulse = bus.shake_pulse;
    endtask

    task automatic send_n(input logic signed [15:0] v, input int n);
        for (int i = 0; i < n; i++) send(v, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.avg_valid, bus.calibrated, bus.shake, bus.shake_pulse} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.avg_valid, bus.calibrated, bus.shake, bus.shake_pulse});
        else pass_cnt++;
        total_cnt++;
        if ({bus.z_avg, bus.baseline, bus.shake_count} !== 40'd0)
            $display("FAIL reset_values: z_avg=%0d baseline=%0d count=%0d expected 0",
                     bus.z_avg, bus.baseline, bus.shake_count);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_fill_cal();
        int early = 0;
        for (int i = 1; i <= 7; i++) begin
            send(16'sd1000, 1'b0);
            if (got_avg_valid) early++;
        end
        total_cnt++;
        if (early !== 0) $display("FAIL fill_no_early_avg: %0d early strobes expected 0", early);
        else pass_cnt++;
        send(16'sd1000, 1'b0);
        total_cnt++;
        if (got_avg_valid !== 1'b1 || got_avg !== 16'sd1000)
            $display("FAIL fill_first_avg: valid=%b avg=%0d expected 1/1000", got_avg_valid, got_avg);
        else pass_cnt++;
        send_n(16'sd1000, 14);   // samples 9..22
        total_cnt++;
        if (bus.calibrated !== 1'b0)
            $display("FAIL cal_not_early: calibrated=%b expected 0", bus.calibrated);
        else pass_cnt++;
        send(16'sd1000, 1'b0);   // sample 23
        total_cnt++;
        if (bus.calibrated !== 1'b1 || bus.baseline !== 16'sd1000)
            $display("FAIL cal_done: calibrated=%b baseline=%0d expected 1/1000",
                     bus.calibrated, bus.baseline);
        else pass_cnt++;
    endtask

    task automatic test_step_shake();
        logic signed [15:0] exp_avg [4] = '{16'sd1225, 16'sd1262, 16'sd1300, 16'sd1300};
        for (int k = 1; k <= 9; k++) begin
            send(16'sd1300, 1'b0);
            if (k >= 6) begin
                total_cnt++;
                if (got_avg !== exp_avg[k-6])
                    $display("FAIL step_avg_%0d: got %0d expected %0d", k, got_avg, exp_avg[k-6]);
                else pass_cnt++;
            end
            if (k == 8) begin
                total_cnt++;
                if (bus.shake !== 1'b0) $display("FAIL step_no_early_shake: shake=%b expected 0", bus.shake);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus.shake !== 1'b1 || got_pulse !== 1'b1 || bus.shake_count !== 8'd1)
            $display("FAIL step_shake: shake=%b pulse=%b count=%0d expected 1/1/1",
                     bus.shake, got_pulse, bus.shake_count);
        else pass_cnt++;
    endtask

    task automatic test_return_quiet();
        for (int k = 1; k <= 8; k++) begin
            send(16'sd1000, 1'b0);
            if (k == 1) begin
                total_cnt++;
                if (got_pulse !== 1'b0) $display("FAIL pulse_one_cycle: pulse=%b expected 0", got_pulse);
                else pass_cnt++;
            end
            if (k == 5) begin
                total_cnt++;
                if (got_avg !== 16'sd1112) $display("FAIL return_avg5: got %0d expected 1112", got_avg);
                else pass_cnt++;
            end
            if (k == 7) begin
                total_cnt++;
                if (bus.shake !== 1'b1) $display("FAIL return_hold: shake=%b expected 1", bus.shake);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus.shake !== 1'b0 || bus.shake_count !== 8'd1)
            $display("FAIL return_release: shake=%b count=%0d expected 0/1", bus.shake, bus.shake_count);
        else pass_cnt++;
    endtask

    task automatic test_threshold_boundary();
        int trips = 0;
        for (int i = 0; i < 50; i++) begin
            send(16'sd1200, 1'b0);
            if (bus.shake) trips++;
        end
        total_cnt++;
        if (trips !== 0) $display("FAIL thresh_equal: shake seen %0d times expected 0", trips);
        else pass_cnt++;
        send_n(16'sd1201, 10);
        total_cnt++;
        if (bus.shake !== 1'b0) $display("FAIL thresh_plus1_early: shake=%b expected 0", bus.shake);
        else pass_cnt++;
        send(16'sd1201, 1'b0);
        total_cnt++;
        if (bus.shake !== 1'b1 || bus.shake_count !== 8'd2)
            $display("FAIL thresh_plus1_trip: shake=%b count=%0d expected 1/2", bus.shake, bus.shake_count);
        else pass_cnt++;
        send_n(16'sd1000, 16);
        total_cnt++;
        if (bus.shake !== 1'b0) $display("FAIL thresh_settle: shake=%b expected 0", bus.shake);
        else pass_cnt++;
    endtask

    task automatic test_recal();
        send_n(16'sd1300, 9);
        total_cnt++;
        if (bus.shake !== 1'b1 || bus.shake_count !== 8'd3)
            $display("FAIL recal_pre_active: shake=%b count=%0d expected 1/3", bus.shake, bus.shake_count);
        else pass_cnt++;
        @(negedge clk);
        bus.recal = 1'b1;
        @(negedge clk);
        bus.recal = 1'b0;
        total_cnt++;
        if (bus.shake !== 1'b0 || bus.calibrated !== 1'b0 || bus.shake_count !== 8'd3)
            $display("FAIL recal_active: shake=%b cal=%b count=%0d expected 0/0/3",
                     bus.shake, bus.calibrated, bus.shake_count);
        else pass_cnt++;
        send_n(16'sd1300, 15);
        send(16'sd1300, 1'b1);   // recal coincident with the 16th average
        total_cnt++;
        if (bus.calibrated !== 1'b0)
            $display("FAIL recal_priority: calibrated=%b expected 0", bus.calibrated);
        else pass_cnt++;
        send_n(16'sd1300, 15);
        total_cnt++;
        if (bus.calibrated !== 1'b0)
            $display("FAIL recal_restart: calibrated=%b expected 0", bus.calibrated);
        else pass_cnt++;
        send(16'sd1300, 1'b0);
        total_cnt++;
        if (bus.calibrated !== 1'b1 || bus.baseline !== 16'sd1300)
            $display("FAIL recal_done: calibrated=%b baseline=%0d expected 1/1300",
                     bus.calibrated, bus.baseline);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_active();
        int early = 0;
        send_n(16'sd1600, 9);
        send_n(16'sd1300, 8);
        send_n(16'sd1600, 9);
        total_cnt++;
        if (bus.shake !== 1'b1 || bus.shake_count !== 8'd5)
            $display("FAIL mid_pre_reset: shake=%b count=%0d expected 1/5", bus.shake, bus.shake_count);
        else pass_cnt++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.z_avg, bus.avg_valid, bus.baseline, bus.calibrated,
             bus.shake, bus.shake_pulse, bus.shake_count} !== 44'd0)
            $display("FAIL mid_async_reset: z_avg=%0d base=%0d cal=%b shake=%b count=%0d expected all 0",
                     bus.z_avg, bus.baseline, bus.calibrated, bus.shake, bus.shake_count);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(16'sd500, 1'b0);
            if (got_avg_valid) early++;
        end
        total_cnt++;
        if (early !== 0) $display("FAIL mid_refill: %0d early strobes expected 0", early);
        else pass_cnt++;
        send(16'sd500, 1'b0);
        total_cnt++;
        if (got_avg_valid !== 1'b1 || got_avg !== 16'sd500 || bus.shake_count !== 8'd0)
            $display("FAIL mid_clean_avg: valid=%b avg=%0d count=%0d expected 1/500/0",
                     got_avg_valid, got_avg, bus.shake_count);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        apply_reset();
        send_n(-16'sd3, 8);
        total_cnt++;
        if (got_avg_valid !== 1'b1 || got_avg !== -16'sd3)
            $display("FAIL neg_avg: valid=%b avg=%0d expected 1/-3", got_avg_valid, got_avg);
        else pass_cnt++;
        send_n(-16'sd3, 15);
        total_cnt++;
        if (bus.calibrated !== 1'b1 || bus.baseline !== -16'sd3)
            $display("FAIL neg_baseline: cal=%b baseline=%0d expected 1/-3", bus.calibrated, bus.baseline);
        else pass_cnt++;
        send_n(-16'sd1, 7);
        send(-16'sd2, 1'b0);     // window sums to -9
        total_cnt++;
        if (got_avg !== -16'sd2) $display("FAIL neg_floor: got %0d expected -2", got_avg);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int early = 0;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.z_data  = 16'(100 * (i + 1));
            bus.z_valid = 1'b1;
            @(negedge clk);
            if (i < 7 && bus.avg_valid) early++;
        end
        bus.z_valid = 1'b0;
        total_cnt++;
        if (early !== 0) $display("FAIL b2b_early: %0d early strobes expected 0", early);
        else pass_cnt++;
        total_cnt++;
        if (bus.avg_valid !== 1'b1 || bus.z_avg !== 16'sd450)
            $display("FAIL b2b_avg: valid=%b avg=%0d expected 1/450", bus.avg_valid, bus.z_avg);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.avg_valid !== 1'b0) $display("FAIL b2b_strobe: avg_valid=%b expected 0", bus.avg_valid);
        else pass_cnt++;
    endtask

    initial begin
        bus.z_data  = '0;
        bus.z_valid = 1'b0;
        bus.recal   = 1'b0;
        reset       = 1'b1;

        test_reset();
        test_fill_cal();
        test_step_shake();
        test_return_quiet();
        test_threshold_boundary();
        test_recal();
        test_reset_mid_active();
        test_negative();
        test_back_to_back();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_z_shake_detector
